// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Sequencer states: normal running, post-branch flush window, memory freeze.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    FREEZE = 2'd2
  } hz_state_t;

  // Register $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the flush-window down-counter (FLUSH_CYCLES is at most 7).
  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: decode/EX/MEM observations in, latch controls out.
// The pipeline drives the master side, hazard_ctrl sits on the slave side.
interface hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       mem_branch_taken;
  logic       mem_busy;

  logic       pc_write;
  logic       ifid_write;
  logic       idex_write;
  logic       exmem_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       exmem_flush;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, mem_branch_taken, mem_busy,
    input  pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_bubble, exmem_flush
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, mem_branch_taken, mem_busy,
    output pc_write, ifid_write, idex_write, exmem_write,
           ifid_flush, idex_bubble, exmem_flush
  );
endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a
// load in EX is about to write. Purely combinational.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  // A load to $zero has no visible result, so it never stalls.
  assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller for the 5-stage MIPS datapath.
// Handles load-use stalls, taken-branch flushes and memory freezes.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  hz_state_t              state_q, state_d;
  hz_state_t              saved_q, saved_d;
  hz_state_t              eff_state;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   load_use;
  logic                   branch_now;
  logic                   frozen;

  load_use_detect u_load_use_detect (
    .id_rs      (hz.id_rs),
    .id_rt      (hz.id_rt),
    .id_uses_rt (hz.id_uses_rt),
    .ex_memread (hz.ex_memread),
    .ex_rt      (hz.ex_rt),
    .load_use   (load_use)
  );

  // Leaving FREEZE resumes the interrupted state; a deferred branch fires then.
  assign frozen     = (state_q == FREEZE);
  assign eff_state  = frozen ? saved_q : state_q;
  assign branch_now = hz.mem_branch_taken || (frozen && pending_q);

  // Next-state and output decode; priority rst > mem_busy > branch > load-use.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d        = state_q;
    saved_d        = saved_q;
    cnt_d          = cnt_q;
    pending_d      = pending_q;
    hz.pc_write    = 1'b1;
    hz.ifid_write  = 1'b1;
    hz.idex_write  = 1'b1;
    hz.exmem_write = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_bubble = 1'b0;
    hz.exmem_flush = 1'b0;

    if (rst) begin
      state_d        = RUN;
      saved_d        = RUN;
      cnt_d          = '0;
      pending_d      = 1'b0;
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_write  = 1'b0;
      hz.exmem_write = 1'b0;
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
      hz.exmem_flush = 1'b1;
    end else if (hz.mem_busy) begin
      // Everything holds; the flush counter is frozen with the pipeline.
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_write  = 1'b0;
      hz.exmem_write = 1'b0;
      state_d        = FREEZE;
      if (!frozen) saved_d = state_q;
      if (hz.mem_branch_taken) pending_d = 1'b1;
    end else if (branch_now) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
      hz.exmem_flush = 1'b1;
      pending_d      = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else if (eff_state == FLUSH) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
      if (cnt_q <= FLUSH_CNT_W'(1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        state_d = FLUSH;
        cnt_d   = cnt_q - FLUSH_CNT_W'(1);
      end
    end else begin
      state_d = RUN;
      if (load_use) begin
        hz.pc_write    = 1'b0;
        hz.ifid_write  = 1'b0;
        hz.idex_bubble = 1'b1;
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    state_q   <= state_d;
    saved_q   <= saved_d;
    cnt_q     <= cnt_d;
    pending_q <= pending_d;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc;
  logic             flush_inc;

  assign stall_inc = !rst && !hz.mem_busy && !branch_now && (eff_state == RUN) && load_use;
  assign flush_inc = !rst && !hz.mem_busy && branch_now;

  // Saturating event counters, cleared by reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES = 3, CNT_W = 4).
// Control vector order: {pc, ifid, idex, exmem writes, ifid_flush, idex_bubble, exmem_flush}.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] stall_cnt;
  logic [3:0] flush_cnt;
`endif

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (hz.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [6:0] V_RST   = 7'b0000_111;
  localparam logic [6:0] V_RUN   = 7'b1111_000;
  localparam logic [6:0] V_STALL = 7'b0011_010;
  localparam logic [6:0] V_BR    = 7'b1111_111;
  localparam logic [6:0] V_FL    = 7'b1111_110;
  localparam logic [6:0] V_FRZ   = 7'b0000_000;

  logic [6:0] ctrl_vec;
  assign ctrl_vec = {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write,
                     hz.ifid_flush, hz.idex_bubble, hz.exmem_flush};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are already set; sample the combinational outputs mid-cycle, then advance.
  task automatic cyc(input string tag, input logic [6:0] exp);
    #2;
    check(tag, {25'd0, ctrl_vec}, {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0;
    hz.ex_memread = 1'b0; hz.ex_rt = 5'd0;
    hz.mem_branch_taken = 1'b0; hz.mem_busy = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic memread, input logic [4:0] ex_rt);
    hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = uses_rt;
    hz.ex_memread = memread; hz.ex_rt = ex_rt;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cyc("reset_c0", V_RST);
    cyc("reset_c1", V_RST);
    rst = 1'b0;
    cyc("run_idle", V_RUN);

    // Load-use on rs, then hazard gone.
    set_lu(5'd8, 5'd0, 1'b0, 1'b1, 5'd8);
    cyc("lu_rs_stall", V_STALL);
    hz.ex_memread = 1'b0;
    cyc("lu_rs_release", V_RUN);
    // Load to $zero never stalls.
    set_lu(5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
    cyc("lu_zero", V_RUN);
    // rt dependency counts only when rt is a source.
    set_lu(5'd3, 5'd5, 1'b1, 1'b1, 5'd5);
    cyc("lu_rt_used", V_STALL);
    hz.id_uses_rt = 1'b0;
    cyc("lu_rt_unused", V_RUN);
    idle();

    // Taken branch: one full flush then two IF/ID+bubble cycles.
    hz.mem_branch_taken = 1'b1;
    cyc("br_flush", V_BR);
    hz.mem_branch_taken = 1'b0;
    cyc("br_fl1", V_FL);
    cyc("br_fl2", V_FL);
    cyc("br_run", V_RUN);
`ifdef HAZARD_PERF_CNT_EN
    check("flush_cnt_1", {28'd0, flush_cnt}, 32'd1);
`endif

    // Freeze four cycles with a branch in cycle 2; it fires after release.
    hz.mem_busy = 1'b1;
    cyc("frz_c1", V_FRZ);
    hz.mem_branch_taken = 1'b1;
    cyc("frz_c2_br", V_FRZ);
    hz.mem_branch_taken = 1'b0;
    cyc("frz_c3", V_FRZ);
    cyc("frz_c4", V_FRZ);
    hz.mem_busy = 1'b0;
    cyc("frz_deferred_br", V_BR);
    cyc("frz_fl1", V_FL);
    cyc("frz_fl2", V_FL);
    cyc("frz_run", V_RUN);

    // Freeze inside the flush window holds the counter.
    hz.mem_branch_taken = 1'b1;
    cyc("mid_br", V_BR);
    hz.mem_branch_taken = 1'b0;
    cyc("mid_fl1", V_FL);
    hz.mem_busy = 1'b1;
    cyc("mid_frz", V_FRZ);
    hz.mem_busy = 1'b0;
    cyc("mid_fl2", V_FL);
    cyc("mid_run", V_RUN);

    // Branch during FLUSH restarts the window.
    hz.mem_branch_taken = 1'b1;
    cyc("rs_br1", V_BR);
    hz.mem_branch_taken = 1'b0;
    cyc("rs_fl1", V_FL);
    hz.mem_branch_taken = 1'b1;
    cyc("rs_br2", V_BR);
    hz.mem_branch_taken = 1'b0;
    cyc("rs_fl2", V_FL);
    cyc("rs_fl3", V_FL);
    cyc("rs_run", V_RUN);

    // Collision: branch beats load-use; load-use also ignored during FLUSH.
    set_lu(5'd8, 5'd0, 1'b0, 1'b1, 5'd8);
    hz.mem_branch_taken = 1'b1;
    cyc("col_br", V_BR);
    hz.mem_branch_taken = 1'b0;
    cyc("col_fl1", V_FL);
    cyc("col_fl2", V_FL);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_col", {28'd0, stall_cnt}, 32'd2);
    check("flush_cnt_col", {28'd0, flush_cnt}, 32'd6);
`endif
    // Load-use under freeze: frozen, not counted.
    hz.mem_busy = 1'b1;
    cyc("lu_frz", V_FRZ);
    hz.mem_busy = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_frz", {28'd0, stall_cnt}, 32'd2);
`endif

    // 20 back-to-back load-use cycles: counter saturates at 15.
    for (int i = 0; i < 20; i++) cyc($sformatf("sat_%0d", i), V_STALL);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_sat", {28'd0, stall_cnt}, 32'd15);
`endif
    idle();

    // A pending branch is discarded by reset.
    hz.mem_busy = 1'b1;
    hz.mem_branch_taken = 1'b1;
    cyc("pend_frz", V_FRZ);
    rst = 1'b1;
    cyc("pend_rst", V_RST);
    rst = 1'b0;
    idle();
    cyc("pend_cleared", V_RUN);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_rst", {28'd0, stall_cnt}, 32'd0);
    check("flush_cnt_rst", {28'd0, flush_cnt}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
